// File: rtl/nx_mesh_host.sv
// Host endpoint for the mesh stream pair: FIFO-buffered TX/RX, 1-cycle latency, ready = !full.
// Sequences the mesh trigger so it fires only once all queued inbound traffic has left.

module nx_mesh_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_dat,
   input  logic         in_vld,
   output logic         in_rdy,
   output logic [W-1:0] out_dat,
   output logic         out_vld,
   input  logic         out_rdy
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic          full, empty, push, pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign in_rdy  = !full;
   assign out_vld = !empty;
   assign out_dat = mem_q[rd_q[AW-1:0]];
   assign push    = in_vld && !full;
   assign pop     = out_rdy && !empty;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push) begin
         mem_d[wr_q[AW-1:0]] = in_dat;
         wr_d                = wr_q + PW'(1);
      end
      if (pop) begin
         rd_d = rd_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         mem_q <= '{default: '0};
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         mem_q <= mem_d;
      end
   end
endmodule

module nx_mesh_host #(
   parameter int STREAM_WIDTH = 32,
   parameter int TX_DEPTH     = 4,
   parameter int RX_DEPTH     = 4,
   parameter int TRIGGER_GAP  = 2,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [STREAM_WIDTH-1:0] host_tx_data_i,
   input  logic                    host_tx_valid_i,
   output logic                    host_tx_ready_o,
   output logic [STREAM_WIDTH-1:0] host_rx_data_o,
   output logic                    host_rx_valid_o,
   input  logic                    host_rx_ready_i,
   input  logic                    host_trigger_i,
   output logic                    host_trigger_busy_o,
   output logic [STREAM_WIDTH-1:0] mesh_ib_data_o,
   output logic                    mesh_ib_valid_o,
   input  logic                    mesh_ib_ready_i,
   input  logic [STREAM_WIDTH-1:0] mesh_ob_data_i,
   input  logic                    mesh_ob_valid_i,
   output logic                    mesh_ob_ready_o,
   output logic                    trigger_o,
   output logic [COUNT_WIDTH-1:0]  tx_count_o,
   output logic [COUNT_WIDTH-1:0]  rx_count_o,
   output logic [COUNT_WIDTH-1:0]  trig_count_o
);
   localparam int GW = (TRIGGER_GAP > 1) ? $clog2(TRIGGER_GAP) : 1;

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FIRE, S_GAP} state_t;

   state_t                 state_q;
   logic                   trig_q;
   logic [GW-1:0]          gap_q;
   logic [COUNT_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
   logic [COUNT_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
   logic [COUNT_WIDTH-1:0] tg_cnt_q, tg_cnt_d;

   nx_mesh_fifo #(.W(STREAM_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk     (clk_i),
      .rst_n   (rst_i),
      .in_dat  (host_tx_data_i),
      .in_vld  (host_tx_valid_i),
      .in_rdy  (host_tx_ready_o),
      .out_dat (mesh_ib_data_o),
      .out_vld (mesh_ib_valid_o),
      .out_rdy (mesh_ib_ready_i)
   );

   nx_mesh_fifo #(.W(STREAM_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk     (clk_i),
      .rst_n   (rst_i),
      .in_dat  (mesh_ob_data_i),
      .in_vld  (mesh_ob_valid_i),
      .in_rdy  (mesh_ob_ready_o),
      .out_dat (host_rx_data_o),
      .out_vld (host_rx_valid_o),
      .out_rdy (host_rx_ready_i)
   );

   // The TX FIFO head is the inbound valid, so "FIFO empty" and "no valid" coincide.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         trig_q  <= 1'b0;
         gap_q   <= '0;
      end else begin
         trig_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (host_trigger_i) state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               if (!mesh_ib_valid_o) begin
                  state_q <= S_FIRE;
                  trig_q  <= 1'b1;
               end
            end
            S_FIRE: begin
               state_q <= S_GAP;
               gap_q   <= '0;
            end
            S_GAP: begin
               if (gap_q == GW'(TRIGGER_GAP - 1)) state_q <= S_IDLE;
               else                               gap_q   <= gap_q + GW'(1);
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      tx_cnt_d = tx_cnt_q;
      rx_cnt_d = rx_cnt_q;
      tg_cnt_d = tg_cnt_q;
      if (mesh_ib_valid_o && mesh_ib_ready_i) tx_cnt_d = tx_cnt_q + COUNT_WIDTH'(1);
      if (mesh_ob_valid_i && mesh_ob_ready_o) rx_cnt_d = rx_cnt_q + COUNT_WIDTH'(1);
      if (state_q == S_FIRE)                  tg_cnt_d = tg_cnt_q + COUNT_WIDTH'(1);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
         tg_cnt_q <= '0;
      end else begin
         tx_cnt_q <= tx_cnt_d;
         rx_cnt_q <= rx_cnt_d;
         tg_cnt_q <= tg_cnt_d;
      end
   end

   assign trigger_o           = trig_q;
   assign host_trigger_busy_o = (state_q != S_IDLE);
   assign tx_count_o          = tx_cnt_q;
   assign rx_count_o          = rx_cnt_q;
   assign trig_count_o        = tg_cnt_q;
endmodule

// File: tb/tb_nx_mesh_host.sv
// Directed bench for nx_mesh_host: linear stimulus with hand-computed expectations.
module tb_nx_mesh_host;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [31:0] host_tx_data_i = '0;
   logic        host_tx_valid_i = 1'b0;
   logic        host_tx_ready_o;
   logic [31:0] host_rx_data_o;
   logic        host_rx_valid_o;
   logic        host_rx_ready_i = 1'b0;
   logic        host_trigger_i = 1'b0;
   logic        host_trigger_busy_o;
   logic [31:0] mesh_ib_data_o;
   logic        mesh_ib_valid_o;
   logic        mesh_ib_ready_i = 1'b0;
   logic [31:0] mesh_ob_data_i = '0;
   logic        mesh_ob_valid_i = 1'b0;
   logic        mesh_ob_ready_o;
   logic        trigger_o;
   logic [15:0] tx_count_o, rx_count_o, trig_count_o;

   int total = 0;
   int bad   = 0;

   nx_mesh_host dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .host_tx_data_i      (host_tx_data_i),
      .host_tx_valid_i     (host_tx_valid_i),
      .host_tx_ready_o     (host_tx_ready_o),
      .host_rx_data_o      (host_rx_data_o),
      .host_rx_valid_o     (host_rx_valid_o),
      .host_rx_ready_i     (host_rx_ready_i),
      .host_trigger_i      (host_trigger_i),
      .host_trigger_busy_o (host_trigger_busy_o),
      .mesh_ib_data_o      (mesh_ib_data_o),
      .mesh_ib_valid_o     (mesh_ib_valid_o),
      .mesh_ib_ready_i     (mesh_ib_ready_i),
      .mesh_ob_data_i      (mesh_ob_data_i),
      .mesh_ob_valid_i     (mesh_ob_valid_i),
      .mesh_ob_ready_o     (mesh_ob_ready_o),
      .trigger_o           (trigger_o),
      .tx_count_o          (tx_count_o),
      .rx_count_o          (rx_count_o),
      .trig_count_o        (trig_count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] exp_q [4];

      // 1. reset state and idle
      #2;
      check("rst_ib_valid", {31'd0, mesh_ib_valid_o}, 32'd0);
      check("rst_rx_valid", {31'd0, host_rx_valid_o}, 32'd0);
      check("rst_trigger",  {31'd0, trigger_o}, 32'd0);
      check("rst_busy",     {31'd0, host_trigger_busy_o}, 32'd0);
      check("rst_ib_data",  mesh_ib_data_o, 32'd0);
      check("rst_rx_data",  host_rx_data_o, 32'd0);
      check("rst_counts",   {tx_count_o, rx_count_o} | {16'd0, trig_count_o}, 32'd0);
      #10 rst_i = 1'b1;
      tick();
      check("idle_tx_ready", {31'd0, host_tx_ready_o}, 32'd1);
      check("idle_ob_ready", {31'd0, mesh_ob_ready_o}, 32'd1);
      check("idle_ib_valid", {31'd0, mesh_ib_valid_o}, 32'd0);

      // 2. streaming A,B,C
      mesh_ib_ready_i = 1'b1;
      host_tx_valid_i = 1'b1;
      host_tx_data_i  = 32'hA;
      tick();
      check("s2_valid", {31'd0, mesh_ib_valid_o}, 32'd1);
      check("s2_dat_a", mesh_ib_data_o, 32'hA);
      host_tx_data_i = 32'hB;
      tick();
      check("s2_dat_b", mesh_ib_data_o, 32'hB);
      host_tx_data_i = 32'hC;
      tick();
      check("s2_dat_c", mesh_ib_data_o, 32'hC);
      host_tx_valid_i = 1'b0;
      tick();
      check("s2_empty", {31'd0, mesh_ib_valid_o}, 32'd0);
      check("s2_txcnt", {16'd0, tx_count_o}, 32'd3);

      // 3. fill, full-with-pop boundary, drain
      mesh_ib_ready_i = 1'b0;
      host_tx_valid_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         host_tx_data_i = i;
         tick();
      end
      check("s3_full_rdy", {31'd0, host_tx_ready_o}, 32'd0);
      host_tx_data_i  = 32'd5;
      mesh_ib_ready_i = 1'b1;
      tick();
      check("s3_reopen", {31'd0, host_tx_ready_o}, 32'd1);
      check("s3_head2",  mesh_ib_data_o, 32'd2);
      mesh_ib_ready_i = 1'b0;
      tick();
      check("s3_refull", {31'd0, host_tx_ready_o}, 32'd0);
      host_tx_valid_i = 1'b0;
      mesh_ib_ready_i = 1'b1;
      exp_q = '{32'd2, 32'd3, 32'd4, 32'd5};
      for (int i = 0; i < 4; i++) begin
         check("s3_drain", mesh_ib_data_o, exp_q[i]);
         tick();
      end
      check("s3_empty", {31'd0, mesh_ib_valid_o}, 32'd0);
      check("s3_txcnt", {16'd0, tx_count_o}, 32'd8);

      // 4. trigger waits for drain, then gap ignores requests
      mesh_ib_ready_i = 1'b0;
      host_tx_valid_i = 1'b1;
      host_tx_data_i  = 32'h10;
      tick();
      host_tx_data_i  = 32'h11;
      tick();
      host_tx_valid_i = 1'b0;
      host_trigger_i  = 1'b1;
      tick();
      host_trigger_i  = 1'b0;
      check("s4_busy", {31'd0, host_trigger_busy_o}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         check("s4_hold", {31'd0, trigger_o}, 32'd0);
         tick();
      end
      mesh_ib_ready_i = 1'b1;
      tick();
      check("s4_pop1", {31'd0, trigger_o}, 32'd0);
      tick();
      check("s4_pop2", {31'd0, trigger_o}, 32'd0);
      tick();
      check("s4_fire", {31'd0, trigger_o}, 32'd1);
      tick();
      check("s4_pulse1", {31'd0, trigger_o}, 32'd0);
      host_trigger_i = 1'b1;
      tick();
      host_trigger_i = 1'b0;
      tick();
      check("s4_idle", {31'd0, host_trigger_busy_o}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("s4_no_refire", {31'd0, trigger_o}, 32'd0);
      end
      check("s4_trigcnt", {16'd0, trig_count_o}, 32'd1);
      check("s4_txcnt",   {16'd0, tx_count_o}, 32'd10);

      // trigger with empty TX side: pulse on the second edge after the request
      host_trigger_i = 1'b1;
      tick();
      host_trigger_i = 1'b0;
      check("s4e_drain", {31'd0, trigger_o}, 32'd0);
      tick();
      check("s4e_fire", {31'd0, trigger_o}, 32'd1);
      tick(); tick(); tick();
      check("s4e_idle",    {31'd0, host_trigger_busy_o}, 32'd0);
      check("s4e_trigcnt", {16'd0, trig_count_o}, 32'd2);

      // 5. RX backpressure and in-order delivery
      host_rx_ready_i = 1'b0;
      mesh_ob_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mesh_ob_data_i = 32'h20 + i;
         tick();
      end
      mesh_ob_data_i = 32'h24;
      check("s5_full_rdy", {31'd0, mesh_ob_ready_o}, 32'd0);
      check("s5_rx_valid", {31'd0, host_rx_valid_o}, 32'd1);
      check("s5_rx20",     host_rx_data_o, 32'h20);
      host_rx_ready_i = 1'b1;
      tick();
      check("s5_rx21",  host_rx_data_o, 32'h21);
      check("s5_reopen", {31'd0, mesh_ob_ready_o}, 32'd1);
      tick();
      mesh_ob_valid_i = 1'b0;
      check("s5_rx22", host_rx_data_o, 32'h22);
      tick();
      check("s5_rx23", host_rx_data_o, 32'h23);
      tick();
      check("s5_rx24", host_rx_data_o, 32'h24);
      tick();
      check("s5_rx_empty", {31'd0, host_rx_valid_o}, 32'd0);
      check("s5_rxcnt",    {16'd0, rx_count_o}, 32'd5);

      // 6. async reset during DRAIN with 3 words queued
      mesh_ib_ready_i = 1'b0;
      host_rx_ready_i = 1'b0;
      host_tx_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         host_tx_data_i = 32'h30 + i;
         tick();
      end
      host_tx_valid_i = 1'b0;
      host_trigger_i  = 1'b1;
      tick();
      host_trigger_i  = 1'b0;
      check("s6_busy", {31'd0, host_trigger_busy_o}, 32'd1);
      #3 rst_i = 1'b0;
      #1;
      check("s6_txcnt0",   {16'd0, tx_count_o}, 32'd0);
      check("s6_rxcnt0",   {16'd0, rx_count_o}, 32'd0);
      check("s6_trigcnt0", {16'd0, trig_count_o}, 32'd0);
      check("s6_busy0",    {31'd0, host_trigger_busy_o}, 32'd0);
      check("s6_ib_valid", {31'd0, mesh_ib_valid_o}, 32'd0);
      check("s6_tx_ready", {31'd0, host_tx_ready_o}, 32'd1);
      mesh_ib_ready_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("s6_no_fire", {31'd0, trigger_o}, 32'd0);
      end
      check("s6_ib_empty", {31'd0, mesh_ib_valid_o}, 32'd0);
      check("s6_rx_empty", {31'd0, host_rx_valid_o}, 32'd0);
      check("s6_txcnt",    {16'd0, tx_count_o}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
